data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Shares the single banked data memory between two requesters: the CPU control unit (micro-sequenced reads/writes) and an external port (loader/debug/DMA). It arbitrates round-robin, then sequences the memory's separate address-write and read/write enables through a fixed multi-cycle access, returning a one-cycle acknowledge to the winner. It sits between the control unit's data-memory control signals and the data memory / memory-bank-select register.

## Interface
Parameters:
- ADDR_WIDTH, 8, byte address within a bank
- DATA_WIDTH, 8, data word width
- BANK_WIDTH, 3, memory bank select width
- ACCESS_CYCLES, 2, cycles read/write enable is held (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_bank  in  BANK_WIDTH  target bank
- cpu_addr  in  ADDR_WIDTH  target address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_wait  out  1  cpu_req & ~cpu_ack; stalls micro-PC advance
- ext_req, ext_we, ext_bank, ext_addr, ext_wdata  in  same as CPU equivalents
- ext_rdata  out  DATA_WIDTH; ext_ack  out  1
- mem_bank  out  BANK_WIDTH  bank to memory
- mem_addr  out  ADDR_WIDTH  address to memory
- mem_wdata  out  DATA_WIDTH  write data to memory
- mem_rdata  in  DATA_WIDTH  memory read data
- mem_addr_wr_enable, mem_read_enable, mem_wr_enable  out  1  memory strobes

## Operation
- States: IDLE, ADDR, ACCESS, DONE.
- IDLE: if any req, grant per round-robin, latch owner's we/bank/addr/wdata into internal registers → ADDR. No req → stay.
- Round-robin: both requesting → grant the port not granted last; single requester always wins. last_grant resets to EXT so CPU wins the first tie.
- ADDR: mem_addr_wr_enable=1 for exactly one cycle → ACCESS.
- ACCESS: mem_read_enable (read) or mem_wr_enable (write) =1 for ACCESS_CYCLES cycles, counted by a down-counter; on final cycle of a read capture mem_rdata into owner's rdata register → DONE.
- DONE: owner's ack=1 one cycle; update last_grant → IDLE.
- mem_bank/mem_addr/mem_wdata driven from latched registers in ADDR through DONE; zero in IDLE.
- Requester must hold req and fields stable until ack; fields are latched, so changes after grant are ignored. Req dropped mid-transaction: transaction still completes, ack still pulses.
- Never both acks, never read and write enables together, never any strobe in IDLE/DONE.
- rdata registers hold last read value until next read by that port; write does not alter them.

## Timing
- Reset: state IDLE, all outputs 0, counter 0, rdata registers 0, last_grant=EXT. Reset mid-transaction aborts immediately; strobes drop asynchronously; no ack issued.
- Req sampled at edge k in IDLE → ADDR during cycle k..k+1 → ACCESS for ACCESS_CYCLES cycles → ack during cycle k+2+ACCESS_CYCLES. Latency ACCESS_CYCLES+2 edges from sampling to ack.
- DONE always returns to IDLE: back-to-back transactions spaced ACCESS_CYCLES+3 cycles; continuous contention alternates CPU/EXT, max wait one transaction.
- Req arriving while busy waits in IDLE of next round; cpu_wait stays high throughout.

## Structure
- Shared package: state encoding (2-bit IDLE=0, ADDR=1, ACCESS=2, DONE=3), port id constants PORT_CPU=0, PORT_EXT=1.
- Sub-module mem_rr_arbiter: two-requester round-robin grant with last_grant register, update input on DONE.

## Test plan
- Reset then CPU read bank 2 addr 0x10, memory returns 0x5A → addr strobe 1 cycle, read strobe 2 cycles, cpu_ack at edge 4 with cpu_rdata=0x5A.
- EXT write bank 1 addr 0x20 data 0xC3 → mem_wr_enable 2 cycles with mem_bank=1, mem_addr=0x20, mem_wdata=0xC3; ext_ack one cycle; no read strobe.
- CPU and EXT both request same edge after reset, held → CPU served first, EXT next; four simultaneous transactions alternate CPU, EXT, CPU, EXT.
- CPU changes cpu_addr 0x10→0x11 and drops req during ACCESS → memory sees 0x10, ack still pulses, IDLE next.
- rst asserted during ACCESS → all strobes and acks 0 asynchronously; after release, pending CPU req restarts at ADDR, CPU wins tie.
- ACCESS_CYCLES=1 and =4 builds → ack at edge 3 and 6 respectively.

Source files
------------

// File: rtl/data_memory_arbiter_pkg.sv
// rtl/data_memory_arbiter_pkg.sv - shared state encoding and port ids for the data memory arbiter
package data_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

endpackage

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - two-requester round-robin grant with last-grant history
module mem_rr_arbiter
  import data_memory_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic ext_req,
  input  logic update,
  input  logic update_port,
  output logic grant
);

  logic last_grant;

  // History starts at EXT so the CPU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_EXT;
    end else if (update) begin
      last_grant <= update_port;
    end
  end

  always_comb begin
    grant = PORT_CPU;
    if (cpu_req && ext_req) begin
      grant = ~last_grant;
    end else if (ext_req) begin
      grant = PORT_EXT;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - round-robin sharing of the banked data memory between CPU and external port
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int BANK_WIDTH    = 3,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [BANK_WIDTH-1:0] cpu_bank,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_wait,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [BANK_WIDTH-1:0] ext_bank,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  ext_ack,
  output logic [BANK_WIDTH-1:0] mem_bank,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_addr_wr_enable,
  output logic                  mem_read_enable,
  output logic                  mem_wr_enable
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_t            state, state_next;
  logic                  owner;
  logic                  grant;
  logic                  any_req;
  logic                  rr_update;
  logic                  lat_we;
  logic [BANK_WIDTH-1:0] lat_bank;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] ext_rdata_q;

  assign any_req   = cpu_req | ext_req;
  assign rr_update = (state == ST_DONE);

  mem_rr_arbiter u_rr (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .ext_req     (ext_req),
    .update      (rr_update),
    .update_port (owner),
    .grant       (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request fields are latched at grant so later changes by the requester are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= PORT_CPU;
      lat_we      <= 1'b0;
      lat_bank    <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      cnt         <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner     <= grant;
            lat_we    <= (grant == PORT_EXT) ? ext_we    : cpu_we;
            lat_bank  <= (grant == PORT_EXT) ? ext_bank  : cpu_bank;
            lat_addr  <= (grant == PORT_EXT) ? ext_addr  : cpu_addr;
            lat_wdata <= (grant == PORT_EXT) ? ext_wdata : cpu_wdata;
          end
        end
        ST_ADDR: cnt <= CNT_LOAD;
        ST_ACCESS: begin
          if (cnt == '0) begin
            if (!lat_we && owner == PORT_CPU) cpu_rdata_q <= mem_rdata;
            if (!lat_we && owner == PORT_EXT) ext_rdata_q <= mem_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (any_req) state_next = ST_ADDR;
      ST_ADDR:   state_next = ST_ACCESS;
      ST_ACCESS: if (cnt == '0) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    mem_bank           = '0;
    mem_addr           = '0;
    mem_wdata          = '0;
    mem_addr_wr_enable = 1'b0;
    mem_read_enable    = 1'b0;
    mem_wr_enable      = 1'b0;
    cpu_ack            = 1'b0;
    ext_ack            = 1'b0;
    if (state != ST_IDLE) begin
      mem_bank  = lat_bank;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
    end
    case (state)
      ST_ADDR:   mem_addr_wr_enable = 1'b1;
      ST_ACCESS: begin
        mem_read_enable = ~lat_we;
        mem_wr_enable   = lat_we;
      end
      ST_DONE: begin
        cpu_ack = (owner == PORT_CPU);
        ext_ack = (owner == PORT_EXT);
      end
      default: ;
    endcase
  end

  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign cpu_wait  = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - directed self-checking bench for data_memory_arbiter
module tb_data_memory_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, ext_req, ext_we;
  logic [2:0] cpu_bank, ext_bank;
  logic [7:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [7:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0] mem_bank;
  logic       cpu_ack, cpu_wait, ext_ack;
  logic       mem_addr_wr_enable, mem_read_enable, mem_wr_enable;

  logic [7:0] mem [0:2047];
  assign mem_rdata = mem[{mem_bank, mem_addr}];

  // Secondary builds with ACCESS_CYCLES of 1 and 4
  logic       q_req;
  logic [7:0] a1_cpu_rdata, a1_ext_rdata, a1_mem_addr, a1_mem_wdata;
  logic [7:0] a4_cpu_rdata, a4_ext_rdata, a4_mem_addr, a4_mem_wdata;
  logic [2:0] a1_mem_bank, a4_mem_bank;
  logic       a1_cpu_ack, a1_cpu_wait, a1_ext_ack, a1_aw, a1_rd, a1_wr;
  logic       a4_cpu_ack, a4_cpu_wait, a4_ext_ack, a4_aw, a4_rd, a4_wr;

  int n_cmp = 0;
  int n_bad = 0;

  int         m_edges, m_aw, m_rd, m_wr, m_wait, m_bad;
  logic       m_cpu, m_ext;
  logic [7:0] m_bank, m_addr, m_wdata;

  always #5 clk = ~clk;

  data_memory_arbiter #(.ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bank(cpu_bank), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .ext_req(ext_req), .ext_we(ext_we), .ext_bank(ext_bank), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_bank(mem_bank), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_wr_enable(mem_addr_wr_enable), .mem_read_enable(mem_read_enable),
    .mem_wr_enable(mem_wr_enable)
  );

  data_memory_arbiter #(.ACCESS_CYCLES(1)) dut_a1 (
    .clk(clk), .rst(rst),
    .cpu_req(q_req), .cpu_we(1'b0), .cpu_bank(3'd0), .cpu_addr(8'h00),
    .cpu_wdata(8'h00), .cpu_rdata(a1_cpu_rdata), .cpu_ack(a1_cpu_ack), .cpu_wait(a1_cpu_wait),
    .ext_req(1'b0), .ext_we(1'b0), .ext_bank(3'd0), .ext_addr(8'h00),
    .ext_wdata(8'h00), .ext_rdata(a1_ext_rdata), .ext_ack(a1_ext_ack),
    .mem_bank(a1_mem_bank), .mem_addr(a1_mem_addr), .mem_wdata(a1_mem_wdata), .mem_rdata(8'h3C),
    .mem_addr_wr_enable(a1_aw), .mem_read_enable(a1_rd), .mem_wr_enable(a1_wr)
  );

  data_memory_arbiter #(.ACCESS_CYCLES(4)) dut_a4 (
    .clk(clk), .rst(rst),
    .cpu_req(q_req), .cpu_we(1'b0), .cpu_bank(3'd0), .cpu_addr(8'h00),
    .cpu_wdata(8'h00), .cpu_rdata(a4_cpu_rdata), .cpu_ack(a4_cpu_ack), .cpu_wait(a4_cpu_wait),
    .ext_req(1'b0), .ext_we(1'b0), .ext_bank(3'd0), .ext_addr(8'h00),
    .ext_wdata(8'h00), .ext_rdata(a4_ext_rdata), .ext_ack(a4_ext_ack),
    .mem_bank(a4_mem_bank), .mem_addr(a4_mem_addr), .mem_wdata(a4_mem_wdata), .mem_rdata(8'h3C),
    .mem_addr_wr_enable(a4_aw), .mem_read_enable(a4_rd), .mem_wr_enable(a4_wr)
  );

  // Memory write lands on the coming edge; inputs/outputs are handled 1 ns after each edge.
  task automatic step();
    if (mem_wr_enable) mem[{mem_bank, mem_addr}] = mem_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic measure();
    m_edges = 0; m_aw = 0; m_rd = 0; m_wr = 0; m_wait = 0; m_bad = 0;
    m_cpu = 1'b0; m_ext = 1'b0; m_bank = 8'h00; m_addr = 8'h00; m_wdata = 8'h00;
    while (m_edges < 30 && !(m_cpu || m_ext)) begin
      step();
      m_edges++;
      if (mem_addr_wr_enable) m_aw++;
      if (mem_read_enable) m_rd++;
      if (mem_wr_enable) m_wr++;
      if (cpu_wait) m_wait++;
      if (mem_read_enable || mem_wr_enable) begin
        m_bank = 8'(mem_bank); m_addr = mem_addr; m_wdata = mem_wdata;
      end
      if ((mem_read_enable && mem_wr_enable) || (cpu_ack && ext_ack)) m_bad++;
      m_cpu = cpu_ack;
      m_ext = ext_ack;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if ({mem_addr_wr_enable, mem_read_enable, mem_wr_enable} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes got %b want 000", {mem_addr_wr_enable, mem_read_enable, mem_wr_enable}); end
    n_cmp++; if ({cpu_ack, ext_ack, cpu_wait} !== 3'b000) begin n_bad++; $display("FAIL reset_acks got %b want 000", {cpu_ack, ext_ack, cpu_wait}); end
    n_cmp++; if ({mem_bank, mem_addr, mem_wdata, cpu_rdata, ext_rdata} !== 35'd0) begin n_bad++; $display("FAIL reset_buses got %h want 0", {mem_bank, mem_addr, mem_wdata, cpu_rdata, ext_rdata}); end
    rst = 1'b0;
  endtask

  task automatic test_cpu_read();
    mem[{3'd2, 8'h10}] = 8'h5A;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_bank = 3'd2; cpu_addr = 8'h10;
    measure();
    n_cmp++; if (m_edges !== 4) begin n_bad++; $display("FAIL rd_latency got %0d want 4", m_edges); end
    n_cmp++; if (m_aw !== 1) begin n_bad++; $display("FAIL rd_addr_strobe got %0d want 1", m_aw); end
    n_cmp++; if (m_rd !== 2) begin n_bad++; $display("FAIL rd_read_strobe got %0d want 2", m_rd); end
    n_cmp++; if (m_wr !== 0) begin n_bad++; $display("FAIL rd_write_strobe got %0d want 0", m_wr); end
    n_cmp++; if ({m_cpu, m_ext} !== 2'b10) begin n_bad++; $display("FAIL rd_ack_owner got %b want 10", {m_cpu, m_ext}); end
    n_cmp++; if (cpu_rdata !== 8'h5A) begin n_bad++; $display("FAIL rd_data got %h want 5a", cpu_rdata); end
    n_cmp++; if ({m_bank, m_addr} !== {8'd2, 8'h10}) begin n_bad++; $display("FAIL rd_location got %h want 0210", {m_bank, m_addr}); end
    n_cmp++; if (m_wait !== 3) begin n_bad++; $display("FAIL rd_wait_cycles got %0d want 3", m_wait); end
    n_cmp++; if (cpu_wait !== 1'b0) begin n_bad++; $display("FAIL rd_wait_at_ack got %b want 0", cpu_wait); end
    cpu_req = 1'b0;
    step();
    n_cmp++; if ({cpu_ack, mem_addr} !== 9'd0) begin n_bad++; $display("FAIL rd_idle_after got %h want 0", {cpu_ack, mem_addr}); end
  endtask

  task automatic test_ext_write();
    ext_req = 1'b1; ext_we = 1'b1; ext_bank = 3'd1; ext_addr = 8'h20; ext_wdata = 8'hC3;
    measure();
    n_cmp++; if (m_edges !== 4) begin n_bad++; $display("FAIL wr_latency got %0d want 4", m_edges); end
    n_cmp++; if ({m_aw, m_rd, m_wr} !== {32'd1, 32'd0, 32'd2}) begin n_bad++; $display("FAIL wr_strobes got aw=%0d rd=%0d wr=%0d want 1 0 2", m_aw, m_rd, m_wr); end
    n_cmp++; if ({m_cpu, m_ext} !== 2'b01) begin n_bad++; $display("FAIL wr_ack_owner got %b want 01", {m_cpu, m_ext}); end
    n_cmp++; if ({m_bank, m_addr, m_wdata} !== {8'd1, 8'h20, 8'hC3}) begin n_bad++; $display("FAIL wr_fields got %h want 0120c3", {m_bank, m_addr, m_wdata}); end
    n_cmp++; if (mem[{3'd1, 8'h20}] !== 8'hC3) begin n_bad++; $display("FAIL wr_mem got %h want c3", mem[{3'd1, 8'h20}]); end
    n_cmp++; if ({ext_rdata, cpu_rdata} !== {8'h00, 8'h5A}) begin n_bad++; $display("FAIL wr_rdata_hold got %h want 005a", {ext_rdata, cpu_rdata}); end
    ext_req = 1'b0; ext_we = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    mem[{3'd3, 8'h30}] = 8'h11;
    mem[{3'd4, 8'h40}] = 8'h22;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_bank = 3'd3; cpu_addr = 8'h30;
    ext_req = 1'b1; ext_we = 1'b0; ext_bank = 3'd4; ext_addr = 8'h40;
    for (int i = 0; i < 4; i++) begin
      measure();
      n_cmp++; if ({m_cpu, m_ext} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_order[%0d] got %b want %b", i, {m_cpu, m_ext}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      n_cmp++; if (m_edges !== ((i == 0) ? 4 : 5)) begin n_bad++; $display("FAIL rr_spacing[%0d] got %0d want %0d", i, m_edges, (i == 0) ? 4 : 5); end
      n_cmp++; if (m_bad !== 0) begin n_bad++; $display("FAIL rr_exclusive[%0d] got %0d want 0", i, m_bad); end
    end
    n_cmp++; if ({cpu_rdata, ext_rdata} !== 16'h1122) begin n_bad++; $display("FAIL rr_rdata got %h want 1122", {cpu_rdata, ext_rdata}); end
    cpu_req = 1'b0; ext_req = 1'b0;
    step();
  endtask

  task automatic test_mid_change();
    mem[{3'd0, 8'h10}] = 8'h77;
    mem[{3'd0, 8'h11}] = 8'h99;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_bank = 3'd0; cpu_addr = 8'h10;
    step();
    step();
    cpu_addr = 8'h11; cpu_req = 1'b0;
    #1;
    n_cmp++; if ({mem_read_enable, mem_addr} !== {1'b1, 8'h10}) begin n_bad++; $display("FAIL chg_addr got %h want 110", {mem_read_enable, mem_addr}); end
    step();
    step();
    n_cmp++; if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h77}) begin n_bad++; $display("FAIL chg_ack got %h want 177", {cpu_ack, cpu_rdata}); end
    step();
    step();
    n_cmp++; if ({cpu_ack, mem_addr_wr_enable, mem_read_enable} !== 3'b000) begin n_bad++; $display("FAIL chg_idle got %b want 000", {cpu_ack, mem_addr_wr_enable, mem_read_enable}); end
  endtask

  task automatic test_reset_abort();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_bank = 3'd6; cpu_addr = 8'h60; cpu_wdata = 8'hDD;
    ext_req = 1'b1; ext_we = 1'b1; ext_bank = 3'd5; ext_addr = 8'h50; ext_wdata = 8'hEE;
    step();
    n_cmp++; if (mem_bank !== 3'd5) begin n_bad++; $display("FAIL abort_grant got %0d want 5", mem_bank); end
    step();
    n_cmp++; if (mem_wr_enable !== 1'b1) begin n_bad++; $display("FAIL abort_access got %b want 1", mem_wr_enable); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({mem_addr_wr_enable, mem_read_enable, mem_wr_enable, cpu_ack, ext_ack} !== 5'd0) begin n_bad++; $display("FAIL abort_async got %b want 00000", {mem_addr_wr_enable, mem_read_enable, mem_wr_enable, cpu_ack, ext_ack}); end
    n_cmp++; if ({mem_bank, cpu_rdata} !== 11'd0) begin n_bad++; $display("FAIL abort_clear got %h want 0", {mem_bank, cpu_rdata}); end
    step();
    rst = 1'b0;
    measure();
    n_cmp++; if ({m_cpu, m_ext, m_edges[7:0]} !== {2'b10, 8'd4}) begin n_bad++; $display("FAIL abort_restart got owner=%b edges=%0d want 10 4", {m_cpu, m_ext}, m_edges); end
    n_cmp++; if ({mem[{3'd6, 8'h60}], mem[{3'd5, 8'h50}]} !== 16'hDD00) begin n_bad++; $display("FAIL abort_mem got %h want dd00", {mem[{3'd6, 8'h60}], mem[{3'd5, 8'h50}]}); end
    cpu_req = 1'b0;
    measure();
    n_cmp++; if ({m_cpu, m_ext} !== 2'b01) begin n_bad++; $display("FAIL abort_ext_next got %b want 01", {m_cpu, m_ext}); end
    ext_req = 1'b0; cpu_we = 1'b0; ext_we = 1'b0;
    step();
  endtask

  task automatic test_access_cycles();
    int e1 = 0;
    int e4 = 0;
    q_req = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (a1_cpu_ack && e1 == 0) e1 = e;
      if (a4_cpu_ack && e4 == 0) e4 = e;
    end
    q_req = 1'b0;
    n_cmp++; if (e1 !== 3) begin n_bad++; $display("FAIL ac1_latency got %0d want 3", e1); end
    n_cmp++; if (e4 !== 6) begin n_bad++; $display("FAIL ac4_latency got %0d want 6", e4); end
    n_cmp++; if ({a1_cpu_rdata, a4_cpu_rdata} !== 16'h3C3C) begin n_bad++; $display("FAIL ac_rdata got %h want 3c3c", {a1_cpu_rdata, a4_cpu_rdata}); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    rst = 1'b1; q_req = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_bank = 3'd0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    ext_req = 1'b0; ext_we = 1'b0; ext_bank = 3'd0; ext_addr = 8'h00; ext_wdata = 8'h00;
    test_reset();
    test_cpu_read();
    test_ext_write();
    test_back_to_back();
    test_mid_change();
    test_reset_abort();
    test_access_cycles();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
